im_port_arbiter: RTL and testbench

- Shares the single-port synchronous instruction memory between the IF-stage fetch path and a program loader/debug port.
- Sequences the memory through boot-load, run and halt phases.
- Gates the fetch stage's PC advance when fetch is denied the port.
- Sits between the pipeline controller/IF stage and the IM macro. IM read latency is 1 cycle, with read data valid the cycle after a CE/address is presented.

---
 rtl/im_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_im_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_port_arbiter.sv
// Purpose: shares the single-port instruction memory between IF-stage fetch and the loader/debug port.
// Latency: grants and IM controls are combinational; fetch_dvalid/ld_rvalid follow one cycle after a grant.
// Backpressure: fetch is stalled (fetch_gnt=0) when denied; a starved loader is forced in after STARVE_LIMIT cycles.
module im_port_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_dvalid,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_done,
    input  logic              ld_halt,
    input  logic              ld_resume,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,

    output logic [1:0]        mode,

    output logic              im_ce,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    input  logic [DATA_W-1:0] im_rdata
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state;
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] wdata_hold;

    // Grant decision: loader owns the port outside RUN; in RUN fetch wins contention until the loader has starved long enough.
    always_comb begin
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (fetch_req && ld_req) begin
                        if (starve_cnt == LIMIT) begin
                            ld_gnt = 1'b1;
                        end else begin
                            fetch_gnt = 1'b1;
                        end
                    end else begin
                        fetch_gnt = fetch_req;
                        ld_gnt    = ld_req;
                    end
                end
                default: begin
                    ld_gnt = ld_req;
                end
            endcase
        end
    end

    // Phase sequencer (BOOT/RUN/HALT) plus the loader starvation counter; halt outranks done/resume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BOOT;
            starve_cnt <= 4'd0;
        end else begin
            if ((state == ST_RUN) && ld_req && !ld_gnt) begin
                if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end

            case (state)
                ST_BOOT: begin
                    if (ld_halt) begin
                        state <= ST_HALT;
                    end else if (ld_done) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ld_halt) begin
                        state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (ld_resume && !ld_halt) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

    // Read-return flags: the IM answers one cycle after a granted access; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_dvalid <= 1'b0;
            ld_rvalid    <= 1'b0;
        end else begin
            fetch_dvalid <= fetch_gnt;
            ld_rvalid    <= ld_gnt & ~ld_we;
        end
    end

    // Mirror of the last address/write data driven to the IM so idle cycles keep the macro inputs stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            if (ld_gnt) begin
                addr_hold  <= ld_addr;
                wdata_hold <= ld_wdata;
            end else if (fetch_gnt) begin
                addr_hold  <= fetch_addr;
            end
        end
    end

    // IM port mux: the granted requester drives the macro, otherwise the held values are replayed with CE low.
    always_comb begin
        im_ce    = 1'b0;
        im_we    = 1'b0;
        im_addr  = addr_hold;
        im_wdata = wdata_hold;
        if (ld_gnt) begin
            im_ce    = 1'b1;
            im_we    = ld_we;
            im_addr  = ld_addr;
            im_wdata = ld_wdata;
        end else if (fetch_gnt) begin
            im_ce    = 1'b1;
            im_addr  = fetch_addr;
        end
    end

    assign ld_rdata = im_rdata;
    assign mode     = state;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Purpose: directed bench for im_port_arbiter with a spec-level model and an IM behavioural macro.
// Latency: stimulus changes 1ns after each rising edge; outputs sampled on the falling edge.
// Backpressure: exercises fetch stalls, loader starvation forcing, halt/resume and async reset.
module tb_im_port_arbiter;
    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_gnt, fetch_dvalid;
    logic          ld_req = 1'b0, ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic          ld_done = 1'b0, ld_halt = 1'b0, ld_resume = 1'b0;
    logic          ld_gnt, ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic [1:0]    mode;
    logic          im_ce, im_we;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_wdata;
    logic [DW-1:0] im_rdata = '0;

    int vectors = 0;
    int errors  = 0;

    im_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_dvalid(fetch_dvalid),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_done(ld_done), .ld_halt(ld_halt), .ld_resume(ld_resume),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mode(mode),
        .im_ce(im_ce), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_rdata(im_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural single-port IM: write-first, one-cycle registered read.
    logic [31:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (im_ce) begin
            if (im_we) begin
                mem[im_addr[5:0]] = im_wdata;
                im_rdata <= im_wdata;
            end else begin
                im_rdata <= mem[im_addr[5:0]];
            end
        end
    end

    // Spec-level model: phase 0/1/2, count of consecutive loader denials in RUN, expected return flags.
    int            m_state  = 0;
    int            m_denied = 0;
    bit            m_fdv = 0, m_lrv = 0;
    bit            have_addr = 0, have_wd = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;

    function automatic void model_grants(output bit fg, output bit lg);
        fg = 0;
        lg = 0;
        if (rst) return;
        if (m_state != 1) begin
            lg = ld_req;
        end else if (fetch_req && ld_req) begin
            lg = (m_denied == LIM);
            fg = !lg;
        end else begin
            fg = fetch_req;
            lg = ld_req;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        bit fg, lg;
        if (rst) begin
            m_state = 0; m_denied = 0; m_fdv = 0; m_lrv = 0;
            have_addr = 0; have_wd = 0;
        end else begin
            model_grants(fg, lg);
            m_fdv = fg;
            m_lrv = lg && !ld_we;
            if (fg) begin m_addr = fetch_addr; have_addr = 1; end
            if (lg) begin m_addr = ld_addr; m_wdata = ld_wdata; have_addr = 1; have_wd = 1; end
            if (m_state == 1 && ld_req && !lg) m_denied = (m_denied + 1 > LIM) ? LIM : m_denied + 1;
            else m_denied = 0;
            if (m_state == 0) m_state = ld_halt ? 2 : (ld_done ? 1 : 0);
            else if (m_state == 1) m_state = ld_halt ? 2 : 1;
            else m_state = (ld_resume && !ld_halt) ? 1 : 2;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        bit fg, lg;
        model_grants(fg, lg);
        chk("fetch_gnt", 32'(fetch_gnt), 32'(fg));
        chk("ld_gnt", 32'(ld_gnt), 32'(lg));
        chk("fetch_dvalid", 32'(fetch_dvalid), 32'(m_fdv));
        chk("ld_rvalid", 32'(ld_rvalid), 32'(m_lrv));
        chk("mode", 32'(mode), 32'(m_state));
        chk("im_ce", 32'(im_ce), 32'(fg | lg));
        chk("im_we", 32'(im_we), 32'(lg & ld_we));
        chk("ld_rdata_pass", ld_rdata, im_rdata);
        if (fg) chk("im_addr_fetch", 32'(im_addr), 32'(fetch_addr));
        else if (lg) begin
            chk("im_addr_ld", 32'(im_addr), 32'(ld_addr));
            chk("im_wdata_ld", im_wdata, ld_wdata);
        end else begin
            if (have_addr) chk("im_addr_hold", 32'(im_addr), 32'(m_addr));
            if (have_wd) chk("im_wdata_hold", im_wdata, m_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, vectors %0d", vectors);
        $fatal(1);
    end

    logic [31:0] wd [0:3];
    logic [13:0] wa [0:3];

    initial begin
        wd[0] = 32'h20080005; wd[1] = 32'h20090007; wd[2] = 32'h01095020; wd[3] = 32'hDEADBEEF;
        wa[0] = 14'd0; wa[1] = 14'd1; wa[2] = 14'd2; wa[3] = 14'd5;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // BOOT: loader writes the image while fetch is held off.
        fetch_req = 1'b1;
        fetch_addr = 14'd0;
        for (int i = 0; i < 4; i++) begin
            ld_req = 1'b1; ld_we = 1'b1; ld_addr = wa[i]; ld_wdata = wd[i];
            @(negedge clk);
            chk("boot_im_we", 32'(im_we), 32'd1);
            chk("boot_fetch_gnt", 32'(fetch_gnt), 32'd0);
            step();
        end
        ld_req = 1'b0; ld_we = 1'b0; ld_done = 1'b1;
        @(negedge clk);
        chk("boot_mode_before_done", 32'(mode), 32'd0);
        step();
        ld_done = 1'b0;
        @(negedge clk);
        chk("run_mode_after_done", 32'(mode), 32'd1);
        chk("run_first_fetch_gnt", 32'(fetch_gnt), 32'd1);

        // RUN: sequential fetch returns the written words one cycle later.
        for (int k = 1; k <= 3; k++) begin
            step();
            fetch_addr = 14'(k);
            @(negedge clk);
            chk("fetch_dvalid_run", 32'(fetch_dvalid), 32'd1);
            chk("fetch_word", ld_rdata, wd[k-1]);
        end

        // Contention: fetch wins four cycles, the starved loader takes the fifth.
        step();
        fetch_addr = 14'd0;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 14'd5;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            chk("starve_ld_gnt", 32'(ld_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
            chk("starve_fetch_gnt", 32'(fetch_gnt), (k % 5 == 4) ? 32'd0 : 32'd1);
            if (k > 0 && k % 5 == 0) begin
                chk("starve_ld_rvalid", 32'(ld_rvalid), 32'd1);
                chk("starve_fetch_dvalid", 32'(fetch_dvalid), 32'd0);
                chk("starve_ld_rdata", ld_rdata, 32'hDEADBEEF);
            end
            step();
        end

        // Halt while fetching, halt+resume together, then resume alone.
        ld_req = 1'b0;
        ld_halt = 1'b1;
        @(negedge clk);
        chk("halt_pulse_fetch_gnt", 32'(fetch_gnt), 32'd1);
        step();
        ld_halt = 1'b0;
        @(negedge clk);
        chk("halt_mode", 32'(mode), 32'd2);
        chk("halt_fetch_gnt", 32'(fetch_gnt), 32'd0);
        step();
        ld_halt = 1'b1; ld_resume = 1'b1;
        step();
        ld_halt = 1'b0; ld_resume = 1'b0;
        @(negedge clk);
        chk("halt_resume_same_cycle", 32'(mode), 32'd2);
        step();
        ld_resume = 1'b1;
        @(negedge clk);
        chk("resume_cycle_mode", 32'(mode), 32'd2);
        chk("resume_cycle_fetch_gnt", 32'(fetch_gnt), 32'd0);
        step();
        ld_resume = 1'b0;
        @(negedge clk);
        chk("resumed_mode", 32'(mode), 32'd1);
        chk("resumed_fetch_gnt", 32'(fetch_gnt), 32'd1);

        // Reset in the cycle a loader read result is returning.
        step();
        fetch_req = 1'b0;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 14'd1;
        step();
        ld_req = 1'b0;
        fetch_req = 1'b1; fetch_addr = 14'd2;
        #1;
        chk("pre_reset_ld_rvalid", 32'(ld_rvalid), 32'd1);
        chk("pre_reset_ld_rdata", ld_rdata, wd[1]);
        rst = 1'b1;
        #1;
        chk("async_ld_rvalid", 32'(ld_rvalid), 32'd0);
        chk("async_fetch_dvalid", 32'(fetch_dvalid), 32'd0);
        chk("async_mode", 32'(mode), 32'd0);
        chk("async_fetch_gnt", 32'(fetch_gnt), 32'd0);
        chk("async_ld_gnt", 32'(ld_gnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("post_reset_fetch_blocked", 32'(fetch_gnt), 32'd0);

        // BOOT with done and halt together must end in HALT.
        step();
        ld_done = 1'b1; ld_halt = 1'b1;
        step();
        ld_done = 1'b0; ld_halt = 1'b0;
        @(negedge clk);
        chk("boot_done_halt_mode", 32'(mode), 32'd2);
        step();
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        @(negedge clk);
        chk("halt_ignores_done", 32'(mode), 32'd2);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
